// File: rtl/gray_counter_if.sv
// Handshake/bus bundle for gray_counter: control and load inputs, binary/Gray
// count outputs and the wrap pulse.
interface gray_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] G;
  logic             wrap;

  modport master (
    output en, up, load, D,
    input  B, G, wrap
  );

  modport slave (
    input  en, up, load, D,
    output B, G, wrap
  );
endinterface

// File: rtl/gray_counter.sv
// Up/down binary counter with synchronous load, a registered Gray-code copy of
// the count and a one-cycle wrap pulse.
module gray_counter #(
  parameter int WIDTH = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  gray_counter_if.slave  bus
);

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH:0]   inc_sum;
  logic [WIDTH:0]   dec_sum;

  // The extra top bit carries the carry-out (increment) or borrow (decrement).
  assign inc_sum = {1'b0, b_q} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_sum = {1'b0, b_q} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    b_d    = b_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      b_d = bus.D;
    end else if (bus.en) begin
      if (bus.up) begin
        b_d    = inc_sum[WIDTH-1:0];
        wrap_d = inc_sum[WIDTH];
      end else begin
        b_d    = dec_sum[WIDTH-1:0];
        wrap_d = dec_sum[WIDTH];
      end
    end
    // Gray is registered from the next binary value so G never lags B.
    g_d = b_d ^ (b_d >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q    <= '0;
      g_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      b_q    <= b_d;
      g_q    <= g_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.B    = b_q;
  assign bus.G    = g_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Randomized self-checking bench for gray_counter against an arithmetic
// reference model of the count, its Gray code and the wrap pulse.
module tb_gray_counter;

  localparam int W   = 3;
  localparam int MOD = 2 ** W;

  logic clk;
  logic rst_n;

  gray_counter_if #(.WIDTH(W)) bus ();

  gray_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: plain integers, wrap derived from modular arithmetic.
  int model_b = 0;
  int model_w = 0;

  function automatic int grayOf(input int v);
    return v ^ (v / 2);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".B"},    {29'b0, bus.B},  model_b);
    checkOutput({tag, ".G"},    {29'b0, bus.G},  grayOf(model_b));
    checkOutput({tag, ".wrap"}, {31'b0, bus.wrap}, model_w);
  endtask

  // Drive inputs, take one edge, advance the model, then check just after the edge.
  task automatic applyStimulus(input logic e, input logic u, input logic l,
                               input int d, input string tag);
    bus.en   = e;
    bus.up   = u;
    bus.load = l;
    bus.D    = d[W-1:0];
    @(posedge clk);
    if (l) begin
      model_b = d % MOD;
      model_w = 0;
    end else if (e) begin
      if (u) begin
        model_w = (model_b + 1 >= MOD) ? 1 : 0;
        model_b = (model_b + 1) % MOD;
      end else begin
        model_w = (model_b == 0) ? 1 : 0;
        model_b = (model_b + MOD - 1) % MOD;
      end
    end else begin
      model_w = 0;
    end
    #1;
    checkAll(tag);
  endtask

  // Called just after an edge: assert reset between edges, check, release before next edge.
  task automatic pulseReset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_b = 0;
    model_w = 0;
    checkOutput({tag, ".B"},    {29'b0, bus.B},    32'd0);
    checkOutput({tag, ".G"},    {29'b0, bus.G},    32'd0);
    checkOutput({tag, ".wrap"}, {31'b0, bus.wrap}, 32'd0);
    #2 rst_n = 1'b1;
  endtask

  logic [W-1:0] prev_g;
  int           prev_b;
  int           gray_seq [9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};

  initial begin
    rst_n    = 1'b0;
    bus.en   = 1'b1;
    bus.up   = 1'b1;
    bus.load = 1'b1;
    bus.D    = 3'd5;

    // Reset takes effect without any clock edge.
    #3;
    checkAll("rst_async");
    // Inputs are ignored while held in reset, even across edges.
    repeat (3) @(posedge clk);
    #1;
    checkAll("rst_held");

    rst_n    = 1'b1;
    bus.load = 1'b0;

    // Up-count through a full wrap, with explicit Gray table as well.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 0, $sformatf("up%0d", i));
      checkOutput($sformatf("up%0d.Gtab", i), {29'b0, bus.G}, gray_seq[i]);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 0, "up9");

    // Down-count from reset wraps to all-ones.
    pulseReset("rst_dn");
    applyStimulus(1'b1, 1'b0, 1'b0, 0, "dn1");
    applyStimulus(1'b1, 1'b0, 1'b0, 0, "dn2");

    // Load overrides enable.
    applyStimulus(1'b0, 1'b0, 1'b1, 2, "ld2");
    applyStimulus(1'b1, 1'b1, 1'b1, 5, "ld5_pri");
    applyStimulus(1'b1, 1'b1, 1'b0, 0, "after_ld");

    // Async reset between edges with en high, then first edge counts.
    bus.en = 1'b1;
    bus.up = 1'b1;
    pulseReset("rst_mid");
    applyStimulus(1'b1, 1'b1, 1'b0, 0, "post_rst");

    // Hold then direction flips.
    applyStimulus(1'b0, 1'b0, 1'b1, 4, "ld4");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 0, $sformatf("hold%0d", i));
    applyStimulus(1'b1, 1'b1, 1'b0, 0, "flip_up");
    applyStimulus(1'b1, 1'b0, 1'b0, 0, "flip_dn");
    applyStimulus(1'b1, 1'b1, 1'b0, 0, "flip_up2");

    // Reset during a wrap pulse clears it at once.
    applyStimulus(1'b0, 1'b0, 1'b1, 7, "ld7");
    applyStimulus(1'b1, 1'b1, 1'b0, 0, "wrap_pulse");
    pulseReset("rst_wrap");

    // Load at a wrap point suppresses wrap; load of current value acts as hold.
    applyStimulus(1'b0, 1'b0, 1'b1, 7, "ld7b");
    applyStimulus(1'b1, 1'b1, 1'b1, 7, "ld_same_wrapsup");
    applyStimulus(1'b1, 1'b1, 1'b0, 0, "wrap_again");
    applyStimulus(1'b1, 1'b0, 1'b1, 0, "ld_same_zero");

    // Random count mode: Gray changes flip exactly one bit.
    for (int i = 0; i < 64; i++) begin
      prev_g = bus.G;
      prev_b = model_b;
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 0,
                    $sformatf("rnd%0d", i));
      if (model_b != prev_b)
        checkOutput($sformatf("rnd%0d.onebit", i), $countones(bus.G ^ prev_g), 32'd1);
    end

    // Random mix including loads.
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) == 0), int'($urandom_range(0, MOD - 1)),
                    $sformatf("mix%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
